// File: rtl/dds_tune_ctrl.sv
// dds_tune_ctrl: turns debounced D-pad up/down levels into the NCO divider word.
// A tap gives one STEP_SLOW step. A held button auto-repeats after HOLD_CYC cycles
// and then every REPEAT_CYC cycles. Once FAST_AFTER repeats have been taken, the
// repeat step grows to STEP_FAST. The divider is clamped to [DIV_MIN, DIV_MAX].
// Ports:
//   clk      - NCO clock
//   rst      - asynchronous active-high reset
//   up, dn   - debounced button levels, synchronous to clk
//   divider  - registered divider word
//   changed  - one-cycle pulse in the first cycle a new divider value is visible
//   at_limit - combinational flag, high while divider sits on DIV_MIN or DIV_MAX
module dds_tune_ctrl #(
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned DIV_INIT   = 0,
  parameter int unsigned DIV_MIN    = 0,
  parameter int unsigned DIV_MAX    = (2**DIV_W) - 1,
  parameter int unsigned STEP_SLOW  = 1,
  parameter int unsigned STEP_FAST  = 16,
  parameter int unsigned HOLD_CYC   = 25000000,
  parameter int unsigned REPEAT_CYC = 5000000,
  parameter int unsigned FAST_AFTER = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up,
  input  logic             dn,
  output logic [DIV_W-1:0] divider,
  output logic             changed,
  output logic             at_limit
);

  localparam int unsigned CNT_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int unsigned TIMER_W = ($clog2(CNT_MAX) > 0) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned REP_W   = ($clog2(FAST_AFTER + 1) > 0) ? $clog2(FAST_AFTER + 1) : 1;
  localparam int unsigned EXT_W   = DIV_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic               dir_up_q, dir_up_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               changed_q, changed_d;

  logic               press_up, press_dn, pressed;
  logic               step_en, step_fast;
  logic [TIMER_W-1:0] timer_last;
  logic [EXT_W-1:0]   step_size, cur_ext, sum_ext;
  logic [DIV_W-1:0]   stepped;

  // Both buttons together count as no press.
  assign press_up = up & ~dn;
  assign press_dn = dn & ~up;
  assign pressed  = press_up | press_dn;

  assign timer_last = (state_q == ST_HOLD) ? TIMER_W'(HOLD_CYC - 1) : TIMER_W'(REPEAT_CYC - 1);

  // Next-state and step decision.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    rep_d     = rep_q;
    dir_up_d  = dir_up_q;
    step_en   = 1'b0;
    step_fast = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pressed) begin
          step_en  = 1'b1;
          dir_up_d = press_up;
          timer_d  = '0;
          rep_d    = '0;
          state_d  = ST_HOLD;
        end
      end
      ST_HOLD, ST_REPEAT: begin
        if (!pressed) begin
          state_d = ST_IDLE;
        end else if (press_up != dir_up_q) begin
          // Reversal behaves like a fresh press in the new direction.
          step_en  = 1'b1;
          dir_up_d = press_up;
          timer_d  = '0;
          rep_d    = '0;
          state_d  = ST_HOLD;
        end else if (timer_q == timer_last) begin
          step_en   = 1'b1;
          step_fast = (rep_q >= REP_W'(FAST_AFTER));
          timer_d   = '0;
          rep_d     = (rep_q >= REP_W'(FAST_AFTER)) ? rep_q : rep_q + REP_W'(1);
          state_d   = ST_REPEAT;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Saturating step computed one bit wider so overflow and underflow are visible.
  assign step_size = step_fast ? EXT_W'(STEP_FAST) : EXT_W'(STEP_SLOW);
  assign cur_ext   = {1'b0, div_q};
  assign sum_ext   = cur_ext + step_size;

  always_comb begin
    stepped = div_q;
    if (dir_up_d) begin
      stepped = (sum_ext > EXT_W'(DIV_MAX)) ? DIV_W'(DIV_MAX) : DIV_W'(sum_ext);
    end else begin
      stepped = (cur_ext < (EXT_W'(DIV_MIN) + step_size)) ? DIV_W'(DIV_MIN)
                                                          : DIV_W'(cur_ext - step_size);
    end
  end

  assign div_d     = step_en ? stepped : div_q;
  assign changed_d = (div_d != div_q);

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      rep_q     <= '0;
      dir_up_q  <= 1'b0;
      div_q     <= DIV_W'(DIV_INIT);
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      rep_q     <= rep_d;
      dir_up_q  <= dir_up_d;
      div_q     <= div_d;
      changed_q <= changed_d;
    end
  end

  assign divider  = div_q;
  assign changed  = changed_q;
  assign at_limit = (div_q == DIV_W'(DIV_MIN)) || (div_q == DIV_W'(DIV_MAX));

endmodule

// File: tb/tb_dds_tune_ctrl.sv
// tb_dds_tune_ctrl: scoreboard bench for dds_tune_ctrl. The reference model counts
// how long the current direction has been held and derives steps from that count.
module tb_dds_tune_ctrl;

  localparam int DIV_W      = 16;
  localparam int DIV_INIT   = 100;
  localparam int DIV_MIN    = 0;
  localparam int DIV_MAX    = 65535;
  localparam int STEP_SLOW  = 1;
  localparam int STEP_FAST  = 16;
  localparam int HOLD_CYC   = 10;
  localparam int REPEAT_CYC = 4;
  localparam int FAST_AFTER = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             up  = 1'b0;
  logic             dn  = 1'b0;
  logic [DIV_W-1:0] divider;
  logic             changed;
  logic             at_limit;

  typedef struct {
    int div;
    bit chg;
    bit lim;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference model state: value, held direction (0 none, 1 up, 2 down), edges held.
  int m_div = DIV_INIT;
  int m_dir = 0;
  int m_n   = 0;

  dds_tune_ctrl #(
    .DIV_W     (DIV_W),
    .DIV_INIT  (DIV_INIT),
    .DIV_MIN   (DIV_MIN),
    .DIV_MAX   (DIV_MAX),
    .STEP_SLOW (STEP_SLOW),
    .STEP_FAST (STEP_FAST),
    .HOLD_CYC  (HOLD_CYC),
    .REPEAT_CYC(REPEAT_CYC),
    .FAST_AFTER(FAST_AFTER)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .up      (up),
    .dn      (dn),
    .divider (divider),
    .changed (changed),
    .at_limit(at_limit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int expv);
    n_chk++;
    if (got == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, expv);
  endtask

  // Predict the outcome of one clock edge with direction d and queue it.
  task automatic model_edge(input int d);
    int  old;
    int  s;
    bit  st;
    exp_t e;
    old = m_div;
    s   = STEP_SLOW;
    st  = 1'b0;
    if (d == 0) begin
      m_dir = 0;
    end else if (d != m_dir) begin
      m_dir = d;
      m_n   = 1;
      st    = 1'b1;
    end else begin
      if (m_n >= HOLD_CYC && ((m_n - HOLD_CYC) % REPEAT_CYC) == 0) begin
        st = 1'b1;
        if ((m_n - HOLD_CYC) / REPEAT_CYC >= FAST_AFTER) s = STEP_FAST;
      end
      m_n++;
    end
    if (st) begin
      m_div = (d == 1) ? m_div + s : m_div - s;
      if (m_div > DIV_MAX) m_div = DIV_MAX;
      if (m_div < DIV_MIN) m_div = DIV_MIN;
    end
    e.div = m_div;
    e.chg = (m_div != old);
    e.lim = (m_div == DIV_MIN) || (m_div == DIV_MAX);
    exp_q.push_back(e);
  endtask

  task automatic step(input bit u, input bit d);
    @(negedge clk);
    up = u;
    dn = d;
    model_edge((u && !d) ? 1 : ((d && !u) ? 2 : 0));
  endtask

  task automatic run(input bit u, input bit d, input int n);
    for (int i = 0; i < n; i++) step(u, d);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs are checked before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("reset_divider", int'(divider), DIV_INIT);
    chk("reset_changed", int'(changed), 0);
    chk("reset_at_limit", int'(at_limit), 0);
    exp_q.delete();
    m_div = DIV_INIT;
    m_dir = 0;
    m_n   = 0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Pops one expectation per clock edge and compares all outputs.
  task automatic monitor();
    forever begin
      @(posedge clk);
      #3;
      if (!rst && exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        n_chk++;
        if (int'(divider) == mon_e.div && changed == mon_e.chg && at_limit == mon_e.lim) begin
          n_pass++;
        end else begin
          $display("FAIL edge_check t=%0t: divider=%0d changed=%0b at_limit=%0b expected %0d/%0b/%0b",
                   $time, divider, changed, at_limit, mon_e.div, mon_e.chg, mon_e.lim);
        end
      end
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    fork
      monitor();
    join_none

    do_reset();

    // Single tap, then a long idle period.
    run(1'b1, 1'b0, 1);
    run(1'b0, 1'b0, 50);
    chk("tap_value", int'(divider), 101);

    // Hold up 40 cycles through the slow and fast repeat phases.
    do_reset();
    run(1'b1, 1'b0, 40);
    run(1'b0, 1'b0, 5);
    chk("hold_value", int'(divider), 184);

    // Both buttons pressed is treated as no press.
    do_reset();
    run(1'b1, 1'b1, 30);
    chk("both_value", int'(divider), 100);

    // Reversal: one slow step down, then the hold delay starts again.
    do_reset();
    run(1'b1, 1'b0, 15);
    run(1'b0, 1'b1, 1);
    run(1'b0, 1'b0, 1);
    chk("reversal_first", int'(divider), 102);
    do_reset();
    run(1'b1, 1'b0, 15);
    run(1'b0, 1'b1, 12);
    run(1'b0, 1'b0, 1);
    chk("reversal_second", int'(divider), 101);

    // Reset mid-hold; the still-held button is a new press after release.
    do_reset();
    run(1'b1, 1'b0, 20);
    do_reset();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("reset_midhold", int'(divider), 101);

    // Lower clamp, then a tap at the limit.
    do_reset();
    run(1'b0, 1'b1, 60);
    run(1'b0, 1'b0, 2);
    chk("min_value", int'(divider), 0);
    chk("min_at_limit", int'(at_limit), 1);
    run(1'b0, 1'b1, 1);
    run(1'b0, 1'b0, 2);
    chk("min_tap_value", int'(divider), 0);

    // Upper clamp reached by a long hold.
    do_reset();
    run(1'b1, 1'b0, 16500);
    chk("max_value", int'(divider), 65535);
    chk("max_at_limit", int'(at_limit), 1);
    run(1'b0, 1'b0, 2);

    // Random press segments with occasional resets.
    for (int seg = 0; seg < 200; seg++) begin
      int kind;
      int len;
      if ($urandom_range(0, 19) == 0) do_reset();
      kind = int'($urandom_range(0, 3));
      len  = int'($urandom_range(1, 45));
      run(kind[0], kind[1], len);
    end

    run(1'b0, 1'b0, 3);
    @(negedge clk);
    chk("queue_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
